// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
//
// Contents:
//   OSR_DEFAULT    baud_pulse ticks per bit
//   rx_state_e     receiver FSM states
//   WLS_*          LCR word-length encodings
//   data_bits()    number of data bits for a wls encoding
//   exp_parity()   parity bit value the line should carry for a character

package uart_pkg;

    localparam int OSR_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    // Unused MSBs are masked so a stale upper bit can never skew parity.
    function automatic logic exp_parity(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps,
                                        input logic       sticky);
        logic [7:0] mask;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        if (sticky)
            return ~eps;
        else if (eps)
            return ^(data & mask);
        else
            return ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - character push bundle from the receiver to the RX FIFO
//
// Signals:
//   push    one-clk strobe, the fields below are valid
//   rx_out  received character, unused MSBs zero
//   pe      parity error
//   fe      framing error
//   bi      break indication
// Modports: master = receiver (drives), slave = FIFO (consumes)

interface uart_rx_if;
    logic       push;
    logic [7:0] rx_out;
    logic       pe;
    logic       fe;
    logic       bi;

    modport master (output push, output rx_out, output pe, output fe, output bi);
    modport slave  (input  push, input  rx_out, input  pe, input  fe, input  bi);
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchronizer with optional 2-of-3 majority bit filter
//
// Build option: RX_MAJORITY_VOTE_EN selects the majority filter over the
// last three baud_pulse captures; otherwise the bit decision is rx_s itself.
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   baud_pulse    16x strobe (majority build only)
//   rx            asynchronous serial input
//   rx_s          synchronized line level
//   rx_bit        bit decision used at the sample point

module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef RX_MAJORITY_VOTE_EN
    input  logic baud_pulse,
`endif
    input  logic rx,
    output logic rx_s,
    output logic rx_bit
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Loaded with 1s so the line looks idle coming out of reset.
    always_ff @(posedge clk) begin
        if (!rst)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
    // Captures from the two previous baud_pulses; combined with the current
    // rx_s they outvote a single-tick glitch at the sample point.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!rst)
            hist_q <= 2'b11;
        else if (baud_pulse)
            hist_q <= {hist_q[0], rx_s};
    end

    assign rx_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver: deframes start, 5-8 data, parity, stop
//
// Build option: RX_MAJORITY_VOTE_EN enables majority filtering in uart_rx_sampler.
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   baud_pulse      one-clk strobe at OSR x bit rate
//   rx              asynchronous serial input, idle high
//   pen, eps        parity enable, even parity select
//   sticky_parity   stick parity
//   wls             word length 00=5 .. 11=8 bits
//   rxo             push bundle to the RX FIFO (push, rx_out, pe, fe, bi)

module uart_rx
    import uart_pkg::*;
#(
    parameter int OSR         = OSR_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_pulse,
    input  logic             rx,
    input  logic             pen,
    input  logic             eps,
    input  logic             sticky_parity,
    input  logic [1:0]       wls,
    uart_rx_if.master        rxo
);

    localparam int OSR_W = $clog2(OSR);
    localparam logic [OSR_W-1:0] HALF_TICK = OSR_W'(OSR / 2 - 1);
    localparam logic [OSR_W-1:0] LAST_TICK = OSR_W'(OSR - 1);

    logic rx_s;
    logic rx_bit;

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
`ifdef RX_MAJORITY_VOTE_EN
        .baud_pulse (baud_pulse),
`endif
        .rx         (rx),
        .rx_s       (rx_s),
        .rx_bit     (rx_bit)
    );

    rx_state_e        state_q, state_d;
    logic [OSR_W-1:0] os_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       data_q;
    logic             par_s;
    logic             line_armed;

    logic             push_q;
    logic [7:0]       rx_out_q;
    logic             pe_q, fe_q, bi_q;

    logic             half_hit;
    logic             mid_hit;
    logic             last_bit;

    logic             frame_start;
    logic             os_clr;
    logic             arm_set;
    logic             shift_en;
    logic             par_en;
    logic             stop_en;

    assign half_hit = baud_pulse && (os_cnt == HALF_TICK);
    assign mid_hit  = baud_pulse && (os_cnt == LAST_TICK);
    assign last_bit = ({1'b0, bit_cnt} == data_bits(wls) - 4'd1);

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (baud_pulse && line_armed && !rx_s) state_d = START;
            START:  if (half_hit) state_d = rx_bit ? IDLE : DATA;
            DATA:   if (mid_hit && last_bit) state_d = pen ? PARITY : STOP;
            PARITY: if (mid_hit) state_d = STOP;
            STOP:   if (mid_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        os_clr      = 1'b0;
        arm_set     = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        stop_en     = 1'b0;
        case (state_q)
            IDLE: begin
                arm_set     = rx_s;
                frame_start = baud_pulse && line_armed && !rx_s;
                os_clr      = frame_start;
            end
            START:  os_clr   = half_hit;
            DATA:   shift_en = mid_hit;
            PARITY: par_en   = mid_hit;
            STOP:   stop_en  = mid_hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            os_cnt     <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            par_s      <= 1'b0;
            line_armed <= 1'b0;
            push_q     <= 1'b0;
            rx_out_q   <= '0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bi_q       <= 1'b0;
        end else begin
            push_q <= 1'b0;

            // Disarming after every frame keeps a held break from retriggering.
            if (stop_en)
                line_armed <= 1'b0;
            else if (arm_set)
                line_armed <= 1'b1;

            if (os_clr)
                os_cnt <= '0;
            else if (baud_pulse)
                os_cnt <= os_cnt + 1'b1;

            if (frame_start) begin
                data_q  <= '0;
                bit_cnt <= '0;
                par_s   <= 1'b0;
            end

            if (shift_en) begin
                data_q[bit_cnt] <= rx_bit;
                bit_cnt         <= bit_cnt + 3'd1;
            end

            if (par_en)
                par_s <= rx_bit;

            if (stop_en) begin
                push_q   <= 1'b1;
                rx_out_q <= data_q;
                pe_q     <= pen && (par_s != exp_parity(data_q, wls, eps, sticky_parity));
                fe_q     <= ~rx_bit;
                bi_q     <= (data_q == 8'd0) && (!par_s || !pen) && !rx_bit;
            end
        end
    end

    assign rxo.push   = push_q;
    assign rxo.rx_out = rx_out_q;
    assign rxo.pe     = pe_q;
    assign rxo.fe     = fe_q;
    assign rxo.bi     = bi_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 96;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    typedef struct {
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       stick;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        exp_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic [1:0] wls = 2'b11;

    uart_rx_if rif ();

    uart_rx dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .wls           (wls),
        .rxo           (rif)
    );

    always #5 clk = ~clk;

    int bcnt = 0;
    always @(negedge clk) begin
        bcnt       = (bcnt == 5) ? 0 : bcnt + 1;
        baud_pulse = (bcnt == 0);
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_expect = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_push(input exp_t e);
        exp_q.push_back(e);
        n_expect++;
    endtask

    logic prev_push = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_push)
            check("push_one_clk", 32'(rif.push), 32'd0);
        prev_push = (rst === 1'b1) && (rif.push === 1'b1);
        if (prev_push) begin
            n_push++;
            check("push_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("push_frame", 32'({rif.rx_out, rif.pe, rif.fe, rif.bi}), 32'(e));
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic use_par,
                              input logic pbit, input logic sbit);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (use_par) send_bit(pbit);
        send_bit(sbit);
        send_bit(1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[8];
    int   pushes_before;

    initial begin
        vecs[0] = '{2'b11, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1, '{8'h13, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{2'b11, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b1, '{8'h13, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{2'b11, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, '{8'h3C, 1'b1, 1'b0, 1'b0}};
        vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, '{8'h3C, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, '{8'h15, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, '{8'h55, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{2'b01, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, '{8'h2A, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, '{8'hFF, 1'b0, 1'b1, 1'b0}};

        // Reset state
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_push",  32'(rif.push),   32'd0);
        check("reset_rx_out", 32'(rif.rx_out), 32'd0);
        check("reset_flags", 32'({rif.pe, rif.fe, rif.bi}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        repeat (BIT_CLKS) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            wls           = vecs[i].wls;
            pen           = vecs[i].pen;
            eps           = vecs[i].eps;
            sticky_parity = vecs[i].stick;
            send_bit(1'b1);
            expect_push(vecs[i].exp);
            send_frame(vecs[i].data, 5 + int'(vecs[i].wls), vecs[i].pen,
                       vecs[i].par_bit, vecs[i].stop_bit);
            check($sformatf("vec%0d_delivered", i), 32'(exp_q.size()), 32'd0);
        end

        // Break held for two frame times, then a clean 8N1 frame
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
        send_bit(1'b1);
        pushes_before = n_push;
        expect_push('{8'h00, 1'b0, 1'b1, 1'b1});
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        send_bit(1'b1);
        expect_push('{8'hA5, 1'b0, 1'b0, 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check("break_push_count", 32'(n_push - pushes_before), 32'd2);
        check("break_delivered", 32'(exp_q.size()), 32'd0);

        // Glitch shorter than half a bit is a false start
        pushes_before = n_push;
        rx = 1'b0;
        repeat (4 * 6) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_no_push", 32'(n_push - pushes_before), 32'd0);
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));

        // Reset in the middle of the data bits
        pushes_before = n_push;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", 32'({rif.push, rif.rx_out, rif.pe, rif.fe, rif.bi}), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("midrst_no_push", 32'(n_push - pushes_before), 32'd0);
        expect_push('{8'h5A, 1'b0, 1'b0, 1'b0});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        check("after_rst_delivered", 32'(exp_q.size()), 32'd0);

        check("total_pushes", 32'(n_push), 32'(n_expect));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
